csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
Non-speculative sequencer that owns the CSR register-file ports while a trap entry or MRET is processed at retire. It steps a fixed series of machine CSR reads and writes (mepc, mcause, mtval, mstatus, mtvec) and emits a single-cycle front-end redirect. It also arbitrates the CSR write port between these sequenced writes and retire-time writes from the CSR functional unit. It sits between retire, the CSR functional unit and the CSR register file.

Parameters:
XLEN, 64, data width of CSRs and PCs.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
trap_i_valid  in  1  exception/interrupt at retire
trap_i_ready  out  1  sequencer can accept a trap or MRET
trap_i_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
trap_i_epc  in  XLEN  PC of faulting instruction
trap_i_tval  in  XLEN  mtval value
mret_i_valid  in  1  MRET retiring; shares trap_i_ready
commit_i_valid  in  1  functional-unit CSR write at retire
commit_i_ready  out  1  write accepted this cycle
commit_i_addr  in  12  CSR address
commit_i_data  in  XLEN  CSR write data
csr_rvalid  out  1  read request
csr_raddr  out  12  read address
csr_rdata  in  XLEN  combinational read data, same cycle
csr_wvalid  out  1  write strobe
csr_waddr  out  12  write address
csr_wdata  out  XLEN  write data
busy_o  out  1  sequencer owns the CSR ports; CSR issue must stall
redirect_o_valid  out  1  one-cycle fetch redirect plus pipeline flush
redirect_o_pc  out  XLEN  redirect target

Behaviour:
- Reset values: all valid and strobe outputs 0; addresses, data and redirect_o_pc 0; state IDLE.
- Reset mid-sequence returns to IDLE. No partial CSR writes are issued after reset.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, R_STATUS, R_EPC.
- trap_i_ready = (state==IDLE). busy_o = (state!=IDLE).
- In IDLE:
  - trap_i_valid takes priority over mret_i_valid if both are set.
  - Trap accepted: latch cause, epc and tval; next state T_EPC.
  - MRET accepted: next state R_STATUS.
- commit_i_ready = (state==IDLE). A commit in IDLE drives the write port that same cycle, including when a trap or MRET is accepted in the same cycle. The commit lands first.
- T_EPC: write mepc (0x341) = epc with bits[1:0] cleared.
- T_CAUSE: write mcause (0x342) = cause.
- T_TVAL: write mtval (0x343) = tval.
- T_STATUS:
  - Read mstatus (0x300) and write back the same cycle.
  - MPIE(7) <= MIE(3); MIE <= 0; MPP[12:11] <= 2'b11; all other bits unchanged.
- T_VEC: read mtvec (0x305); base = rdata with bits[1:0] cleared.
  - If mode rdata[1:0]==01 and cause[XLEN-1]==1: target = base + 4*cause[XLEN-2:0]. Unsigned, truncated to XLEN.
  - Otherwise target = base.
  - Pulse redirect_o_valid with the target; go to IDLE.
- R_STATUS: read mstatus; write MIE <= MPIE, MPIE <= 1, MPP <= 2'b00; other bits unchanged.
- R_EPC: read mepc; redirect to mepc with bits[1:0] cleared; go to IDLE.
- Latency:
  - Trap: accept at cycle N, redirect at N+5.
  - MRET: accept at N, redirect at N+2.
- At most one csr_wvalid per cycle. csr_rvalid is asserted only in T_STATUS, T_VEC, R_STATUS and R_EPC.
- trap_i_valid or mret_i_valid while busy is not accepted; the source holds the request.
- Writes the sequencer itself makes are visible to its later reads through the register file (write lands at clock edge N, read at N+1).

Decomposition:
- Shared package:
  - CSR address constants (CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MTVEC).
  - mstatus bit-position constants (MIE, MPIE, MPP).
  - The seq_state_t enum.
- Sub-module csr_port_mux: combinational selection of the write and read ports between the commit path and the sequencer.

Test Plan:
1. Reset with trap_i_valid=1 held -> all outputs 0. First trap accepted on the first cycle after rstn rises.
2. Trap: cause=2, epc=0x8000_0102, tval=0xDEAD, mstatus=0x8, mtvec=0x8000_1000.
   -> Writes on successive cycles: mepc=0x8000_0100, mcause=2, mtval=0xDEAD, mstatus=0x1880.
   -> Redirect to 0x8000_1000 at N+5.
3. Vectored interrupt: cause=(1<<63)|7, mtvec=0x8000_1001 -> redirect 0x8000_101C.
4. MRET: mstatus=0x1880, mepc=0x8000_0200 -> mstatus write 0x88, redirect 0x8000_0200 at N+2.
5. Commit write (addr 0x340, data 5) in the same IDLE cycle as trap accept -> csr_wvalid with 0x340 that cycle, mepc write the next cycle. A commit during busy sees commit_i_ready=0 until IDLE.
6. rstn low while in T_TVAL -> IDLE the next cycle; no mstatus write and no redirect.

Source files
------------

// File: rtl/csr_trap_seq_pkg.sv
// csr_trap_seq_pkg: CSR addresses, mstatus bit positions and sequencer states.
package csr_trap_seq_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;
  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, R_STATUS, R_EPC
  } seq_state_t;
endpackage

// File: rtl/csr_trap_seq_port_mux.sv
// csr_port_mux: steers the CSR write/read ports between retire commits and the sequencer.
module csr_port_mux
  import csr_trap_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_en,
  input  logic            i_idle,
  input  logic            i_commit_valid,
  input  logic [11:0]     i_commit_addr,
  input  logic [XLEN-1:0] i_commit_data,
  input  logic            i_seq_wvalid,
  input  logic [11:0]     i_seq_waddr,
  input  logic [XLEN-1:0] i_seq_wdata,
  input  logic            i_seq_rvalid,
  input  logic [11:0]     i_seq_raddr,
  output logic            o_commit_ready,
  output logic            o_wvalid,
  output logic [11:0]     o_waddr,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_rvalid,
  output logic [11:0]     o_raddr
);
  logic w_commit, w_seq_w;
  // Commits only own the port while idle, so the two writers never collide.
  assign w_commit       = i_en & i_idle & i_commit_valid;
  assign w_seq_w        = i_en & ~i_idle & i_seq_wvalid;
  assign o_commit_ready = i_en & i_idle;
  assign o_wvalid       = w_commit | w_seq_w;
  assign o_waddr        = w_commit ? i_commit_addr : w_seq_w ? i_seq_waddr : '0;
  assign o_wdata        = w_commit ? i_commit_data : w_seq_w ? i_seq_wdata : '0;
  assign o_rvalid       = i_en & i_seq_rvalid;
  assign o_raddr        = o_rvalid ? i_seq_raddr : '0;
endmodule

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: steps the machine CSR updates for trap entry and MRET, then redirects fetch.
module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            trap_i_valid,
  output logic            trap_i_ready,
  input  logic [XLEN-1:0] trap_i_cause,
  input  logic [XLEN-1:0] trap_i_epc,
  input  logic [XLEN-1:0] trap_i_tval,
  input  logic            mret_i_valid,
  input  logic            commit_i_valid,
  output logic            commit_i_ready,
  input  logic [11:0]     commit_i_addr,
  input  logic [XLEN-1:0] commit_i_data,
  output logic            csr_rvalid,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wvalid,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy_o,
  output logic            redirect_o_valid,
  output logic [XLEN-1:0] redirect_o_pc
);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
  seq_state_t r_state, w_state_nx;
  logic [XLEN-1:0] r_cause, r_epc, r_tval;
  logic w_idle, w_wvalid, w_rvalid, w_redir;
  logic [11:0] w_waddr, w_raddr;
  logic [XLEN-1:0] w_wdata, w_target, w_base;
  assign w_idle = r_state == IDLE;
  assign w_base = csr_rdata & ALIGN;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_idle && trap_i_valid) begin
        r_cause <= trap_i_cause;
        r_epc   <= trap_i_epc;
        r_tval  <= trap_i_tval;
      end
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_wvalid   = 1'b0;
    w_waddr    = '0;
    w_wdata    = '0;
    w_rvalid   = 1'b0;
    w_raddr    = '0;
    w_redir    = 1'b0;
    w_target   = '0;
    case (r_state)
      IDLE:     w_state_nx = trap_i_valid ? T_EPC : mret_i_valid ? R_STATUS : IDLE;
      T_EPC: begin
        w_state_nx = T_CAUSE;
        w_wvalid   = 1'b1;
        w_waddr    = CSR_MEPC;
        w_wdata    = r_epc & ALIGN;
      end
      T_CAUSE: begin
        w_state_nx = T_TVAL;
        w_wvalid   = 1'b1;
        w_waddr    = CSR_MCAUSE;
        w_wdata    = r_cause;
      end
      T_TVAL: begin
        w_state_nx = T_STATUS;
        w_wvalid   = 1'b1;
        w_waddr    = CSR_MTVAL;
        w_wdata    = r_tval;
      end
      T_STATUS: begin
        w_state_nx            = T_VEC;
        w_rvalid              = 1'b1;
        w_raddr               = CSR_MSTATUS;
        w_wvalid              = 1'b1;
        w_waddr               = CSR_MSTATUS;
        w_wdata               = csr_rdata;
        w_wdata[MPIE]         = csr_rdata[MIE];
        w_wdata[MIE]          = 1'b0;
        w_wdata[MPP_HI:MPP_LO] = 2'b11;
      end
      T_VEC: begin
        w_state_nx = IDLE;
        w_rvalid   = 1'b1;
        w_raddr    = CSR_MTVEC;
        w_redir    = 1'b1;
        // Vectored mode only applies to interrupts; exceptions always use the base.
        w_target   = (csr_rdata[1:0] == 2'b01 && r_cause[XLEN-1])
                   ? w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
      end
      R_STATUS: begin
        w_state_nx            = R_EPC;
        w_rvalid              = 1'b1;
        w_raddr               = CSR_MSTATUS;
        w_wvalid              = 1'b1;
        w_waddr               = CSR_MSTATUS;
        w_wdata               = csr_rdata;
        w_wdata[MIE]          = csr_rdata[MPIE];
        w_wdata[MPIE]         = 1'b1;
        w_wdata[MPP_HI:MPP_LO] = 2'b00;
      end
      R_EPC: begin
        w_state_nx = IDLE;
        w_rvalid   = 1'b1;
        w_raddr    = CSR_MEPC;
        w_redir    = 1'b1;
        w_target   = w_base;
      end
      default:  w_state_nx = IDLE;
    endcase
  end
  csr_port_mux #(.XLEN(XLEN)) u_mux (
    .i_en           (rstn),
    .i_idle         (w_idle),
    .i_commit_valid (commit_i_valid),
    .i_commit_addr  (commit_i_addr),
    .i_commit_data  (commit_i_data),
    .i_seq_wvalid   (w_wvalid),
    .i_seq_waddr    (w_waddr),
    .i_seq_wdata    (w_wdata),
    .i_seq_rvalid   (w_rvalid),
    .i_seq_raddr    (w_raddr),
    .o_commit_ready (commit_i_ready),
    .o_wvalid       (csr_wvalid),
    .o_waddr        (csr_waddr),
    .o_wdata        (csr_wdata),
    .o_rvalid       (csr_rvalid),
    .o_raddr        (csr_raddr)
  );
  // Outputs are held quiet while reset is asserted, even if the state is mid-sequence.
  assign trap_i_ready     = rstn & w_idle;
  assign busy_o           = rstn & ~w_idle;
  assign redirect_o_valid = rstn & w_redir;
  assign redirect_o_pc    = redirect_o_valid ? w_target : '0;
endmodule

// File: tb/tb_csr_trap_seq.sv
// tb_csr_trap_seq: directed checks of trap entry, MRET, commit arbitration and reset abort.
module tb_csr_trap_seq;
  logic clk = 1'b0;
  logic rstn;
  logic trap_i_valid, trap_i_ready, mret_i_valid;
  logic [63:0] trap_i_cause, trap_i_epc, trap_i_tval;
  logic commit_i_valid, commit_i_ready;
  logic [11:0] commit_i_addr;
  logic [63:0] commit_i_data;
  logic csr_rvalid, csr_wvalid, busy_o, redirect_o_valid;
  logic [11:0] csr_raddr, csr_waddr;
  logic [63:0] csr_rdata, csr_wdata, redirect_o_pc;
  logic pl_en;
  logic [11:0] pl_addr;
  logic [63:0] pl_data;
  logic [63:0] rf [4096];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_trap_seq #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .trap_i_valid(trap_i_valid), .trap_i_ready(trap_i_ready),
    .trap_i_cause(trap_i_cause), .trap_i_epc(trap_i_epc), .trap_i_tval(trap_i_tval),
    .mret_i_valid(mret_i_valid),
    .commit_i_valid(commit_i_valid), .commit_i_ready(commit_i_ready),
    .commit_i_addr(commit_i_addr), .commit_i_data(commit_i_data),
    .csr_rvalid(csr_rvalid), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wvalid(csr_wvalid), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .busy_o(busy_o), .redirect_o_valid(redirect_o_valid), .redirect_o_pc(redirect_o_pc)
  );

  assign csr_rdata = rf[csr_raddr];
  always @(posedge clk)
    if (csr_wvalid) rf[csr_waddr] <= csr_wdata;
    else if (pl_en) rf[pl_addr] <= pl_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_w(input string tag, input logic [11:0] a, input logic [63:0] d);
    chk({tag, "_wv"}, {63'd0, csr_wvalid}, 64'd1);
    chk({tag, "_wa"}, {52'd0, csr_waddr}, {52'd0, a});
    chk({tag, "_wd"}, csr_wdata, d);
  endtask

  task automatic start_trap(input logic [63:0] c, input logic [63:0] e, input logic [63:0] t);
    @(negedge clk);
    trap_i_valid = 1'b1; trap_i_cause = c; trap_i_epc = e; trap_i_tval = t;
    #1 chk("acc_rdy", {63'd0, trap_i_ready}, 64'd1);
  endtask

  initial begin
    rstn = 1'b0; trap_i_valid = 1'b1; mret_i_valid = 1'b0;
    trap_i_cause = 64'd2; trap_i_epc = 64'h8000_0102; trap_i_tval = 64'hDEAD;
    commit_i_valid = 1'b0; commit_i_addr = '0; commit_i_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    // 1. reset with trap held
    preload(12'h300, 64'h8);
    preload(12'h305, 64'h8000_1000);
    #1;
    chk("rst_trdy", {63'd0, trap_i_ready}, 64'd0);
    chk("rst_crdy", {63'd0, commit_i_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_wv", {63'd0, csr_wvalid}, 64'd0);
    chk("rst_rv", {63'd0, csr_rvalid}, 64'd0);
    chk("rst_rd", {63'd0, redirect_o_valid}, 64'd0);
    chk("rst_pc", redirect_o_pc, 64'd0);
    chk("rst_wa", {52'd0, csr_waddr}, 64'd0);
    // 2. trap accepted on first cycle after reset
    @(negedge clk); rstn = 1'b1;
    #1 chk("t_acc", {63'd0, trap_i_ready}, 64'd1);
    @(negedge clk); trap_i_valid = 1'b0;
    #1 chk_w("t_epc", 12'h341, 64'h8000_0100);
    chk("t_busy", {63'd0, busy_o}, 64'd1);
    chk("t_trdy", {63'd0, trap_i_ready}, 64'd0);
    chk("t_rv0", {63'd0, csr_rvalid}, 64'd0);
    @(negedge clk); #1 chk_w("t_cause", 12'h342, 64'd2);
    @(negedge clk); #1 chk_w("t_tval", 12'h343, 64'hDEAD);
    @(negedge clk); #1 chk_w("t_mst", 12'h300, 64'h1880);
    chk("t_mst_ra", {52'd0, csr_raddr}, 64'h300);
    chk("t_rd_early", {63'd0, redirect_o_valid}, 64'd0);
    @(negedge clk);
    #1 chk("t_redir", {63'd0, redirect_o_valid}, 64'd1);
    chk("t_pc", redirect_o_pc, 64'h8000_1000);
    chk("t_vec_ra", {52'd0, csr_raddr}, 64'h305);
    chk("t_vec_wv", {63'd0, csr_wvalid}, 64'd0);
    @(negedge clk);
    #1 chk("t_idle", {63'd0, busy_o}, 64'd0);
    chk("t_rd_off", {63'd0, redirect_o_valid}, 64'd0);
    chk("t_rf_mst", rf[12'h300], 64'h1880);
    // 3. vectored interrupt
    preload(12'h305, 64'h8000_1001);
    start_trap({1'b1, 63'd7}, 64'h8000_0400, 64'd0);
    @(negedge clk); trap_i_valid = 1'b0;
    #1 chk_w("v_epc", 12'h341, 64'h8000_0400);
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 chk("v_redir", {63'd0, redirect_o_valid}, 64'd1);
    chk("v_pc", redirect_o_pc, 64'h8000_101C);
    // 4. MRET
    preload(12'h300, 64'h1880);
    preload(12'h341, 64'h8000_0200);
    @(negedge clk); mret_i_valid = 1'b1;
    #1 chk("m_acc", {63'd0, trap_i_ready}, 64'd1);
    @(negedge clk); mret_i_valid = 1'b0;
    #1 chk_w("m_mst", 12'h300, 64'h88);
    chk("m_rv", {63'd0, csr_rvalid}, 64'd1);
    chk("m_rd_early", {63'd0, redirect_o_valid}, 64'd0);
    @(negedge clk);
    #1 chk("m_redir", {63'd0, redirect_o_valid}, 64'd1);
    chk("m_pc", redirect_o_pc, 64'h8000_0200);
    chk("m_ra", {52'd0, csr_raddr}, 64'h341);
    @(negedge clk);
    #1 chk("m_idle", {63'd0, busy_o}, 64'd0);
    chk("m_rf_mst", rf[12'h300], 64'h88);
    // 5. commit with simultaneous trap and MRET; trap wins, commit lands first
    @(negedge clk);
    trap_i_valid = 1'b1; mret_i_valid = 1'b1;
    trap_i_cause = 64'd5; trap_i_epc = 64'h8000_0600; trap_i_tval = 64'd0;
    commit_i_valid = 1'b1; commit_i_addr = 12'h340; commit_i_data = 64'd5;
    #1 chk("c_crdy", {63'd0, commit_i_ready}, 64'd1);
    chk_w("c_commit", 12'h340, 64'd5);
    @(negedge clk); trap_i_valid = 1'b0; mret_i_valid = 1'b0;
    #1 chk_w("c_epc", 12'h341, 64'h8000_0600);
    chk("c_crdy_busy", {63'd0, commit_i_ready}, 64'd0);
    chk("c_rf_340", rf[12'h340], 64'd5);
    repeat (4) @(negedge clk);
    #1 chk("c_crdy_vec", {63'd0, commit_i_ready}, 64'd0);
    chk("c_vec_redir", {63'd0, redirect_o_valid}, 64'd1);
    @(negedge clk); commit_i_data = 64'd9;
    #1 chk("c_crdy_idle", {63'd0, commit_i_ready}, 64'd1);
    chk_w("c_commit2", 12'h340, 64'd9);
    @(negedge clk); commit_i_valid = 1'b0;
    // 6. reset while in T_TVAL
    preload(12'h300, 64'h8);
    start_trap(64'd3, 64'h8000_0800, 64'h55);
    @(negedge clk); trap_i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rstn = 1'b0;
    #1 chk("r_wv_inrst", {63'd0, csr_wvalid}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    #1 chk("r_busy", {63'd0, busy_o}, 64'd0);
    chk("r_trdy", {63'd0, trap_i_ready}, 64'd1);
    chk("r_wv", {63'd0, csr_wvalid}, 64'd0);
    @(negedge clk);
    #1 chk("r_rd", {63'd0, redirect_o_valid}, 64'd0);
    chk("r_wv2", {63'd0, csr_wvalid}, 64'd0);
    @(negedge clk);
    #1 chk("r_rf_mst", rf[12'h300], 64'h8);
    chk("r_rf_tval", rf[12'h343], 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
